hub75_row_driver: RTL and testbench

//  Downstream consumer of the pattern generator's row stream. Shifts one rgb_row_t row out on the HUB75 panel pins,

---
 rtl/led_display_pkg.sv | 42 ++++
 rtl/hub75_row_driver_if.sv | 31 +++
 rtl/hub75_tick_gen.sv | 46 ++++
 rtl/hub75_row_driver.sv | 258 +++++++++++++++++++++++++
 tb/tb_hub75_row_driver.sv | 302 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/led_display_pkg.sv
// rtl/led_display_pkg.sv - shared row types, geometry constants and row-driver state enum
//
// Purpose : common definitions for the LED display pipeline (pattern generator -> row driver).
// Contents: GL_NUM_COL_PIXELS  columns per panel row
//           GL_RGB_COL_W       bits in one half-row (red, green and blue column vectors)
//           GL_RGB_ROW_W       bits in one rgb_row_t (top half + bottom half)
//           rgb_row_t          top/bot halves, each {red, green, blue} column vectors
//           hub75_state_t      row-driver FSM states
//           half_bits()        {r,g,b} of one column of a half-row
package led_display_pkg;

    localparam int GL_NUM_COL_PIXELS = 32;
    localparam int GL_RGB_COL_W      = 3 * GL_NUM_COL_PIXELS;
    localparam int GL_RGB_ROW_W      = 2 * GL_RGB_COL_W;
    localparam int GL_COL_IDX_W      = $clog2(GL_NUM_COL_PIXELS);

    typedef logic [GL_NUM_COL_PIXELS-1:0] col_vec_t;

    typedef struct packed {
        col_vec_t red;
        col_vec_t green;
        col_vec_t blue;
    } rgb_half_t;

    typedef struct packed {
        rgb_half_t top;
        rgb_half_t bot;
    } rgb_row_t;

    typedef enum logic [2:0] {
        IDLE,
        SHIFT,
        BLANK,
        LATCH,
        DISPLAY
    } hub75_state_t;

    function automatic logic [2:0] half_bits(input rgb_half_t h, input logic [GL_COL_IDX_W-1:0] idx);
        return {h.red[idx], h.green[idx], h.blue[idx]};
    endfunction

endpackage

// File: rtl/hub75_row_driver_if.sv
// rtl/hub75_row_driver_if.sv - row stream handshake between pattern generator and row driver
//
// Purpose : one rgb_row_t plus its panel row-pair address per valid/ready transfer.
// Signals : row_in          rgb_row_t row data
//           row_valid_in    row_in and row_address_in valid
//           row_ready_out   driver can accept a row
//           row_address_in  4-bit panel row-pair address
// Modports: master (pattern generator), slave (row driver).
interface hub75_row_driver_if;
    import led_display_pkg::*;

    rgb_row_t    row_in;
    logic        row_valid_in;
    logic        row_ready_out;
    logic [3:0]  row_address_in;

    modport master (
        output row_in,
        output row_valid_in,
        output row_address_in,
        input  row_ready_out
    );

    modport slave (
        input  row_in,
        input  row_valid_in,
        input  row_address_in,
        output row_ready_out
    );

endinterface

// File: rtl/hub75_tick_gen.sv
// rtl/hub75_tick_gen.sv - shift-clock divider producing alternating rise/fall ticks
//
// Purpose : while en_in=1, emits a one-cycle tick every DIV cycles; ticks alternate rise, fall,
//           rise, ... starting with rise. Dropping en_in restarts the sequence.
// Ports   : clk_in         system clock
//           reset_in       asynchronous active-high reset
//           en_in          run the divider
//           rise_tick_out  the shift clock should go high next cycle
//           fall_tick_out  the shift clock should go low next cycle
module hub75_tick_gen #(
    parameter int DIV = 2
) (
    input  logic clk_in,
    input  logic reset_in,
    input  logic en_in,
    output logic rise_tick_out,
    output logic fall_tick_out
);

    localparam int              CNT_W    = $clog2(DIV + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DIV - 1);

    logic [CNT_W-1:0] cnt_q;
    logic             phase_q;
    logic             tick;

    assign tick          = en_in && (cnt_q == CNT_LAST);
    assign rise_tick_out = tick && !phase_q;
    assign fall_tick_out = tick && phase_q;

    always_ff @(posedge clk_in or posedge reset_in) begin
        if (reset_in) begin
            cnt_q   <= '0;
            phase_q <= 1'b0;
        end else if (!en_in) begin
            cnt_q   <= '0;
            phase_q <= 1'b0;
        end else if (tick) begin
            cnt_q   <= '0;
            phase_q <= !phase_q;
        end else begin
            cnt_q   <= cnt_q + 1'b1;
        end
    end

endmodule

// File: rtl/hub75_row_driver.sv
// rtl/hub75_row_driver.sv - shifts one row onto HUB75 pins, then blanks, latches and displays it
//
// Purpose : accepts rows from the pattern generator and drives the panel connector:
//           IDLE -> SHIFT -> BLANK -> LATCH -> DISPLAY -> IDLE. All outputs registered.
// Ports   : clk_in, reset_in        system clock, asynchronous active-high reset
//           row_if (slave)          row_in / row_valid_in / row_ready_out / row_address_in
//           brightness_in [7:0]     only with HUB75_BRIGHTNESS_EN; sampled on entry to DISPLAY
//           hub_{r,g,b}1_out        top-half serial colour data
//           hub_{r,g,b}2_out        bottom-half serial colour data
//           hub_clk_out             panel shift clock
//           hub_lat_out             panel latch
//           hub_oe_n_out            panel output enable, active low
//           hub_addr_out [3:0]      panel row select
//           row_done_out            one-cycle pulse on the last DISPLAY cycle
// Config  : HUB75_BRIGHTNESS_EN     oe_n low only for brightness*(OE_ON_CYCLES/256) DISPLAY cycles
module hub75_row_driver
    import led_display_pkg::*;
#(
    parameter int SYS_CLK_FREQ  = 100_000_000,
    parameter int SHIFT_CLK_DIV = 2,
    parameter int BLANK_CYCLES  = 4,
    parameter int OE_ON_CYCLES  = 2560
) (
    input  logic               clk_in,
    input  logic               reset_in,
    hub75_row_driver_if.slave  row_if,
`ifdef HUB75_BRIGHTNESS_EN
    input  logic [7:0]         brightness_in,
`endif
    output logic               hub_r1_out,
    output logic               hub_g1_out,
    output logic               hub_b1_out,
    output logic               hub_r2_out,
    output logic               hub_g2_out,
    output logic               hub_b2_out,
    output logic               hub_clk_out,
    output logic               hub_lat_out,
    output logic               hub_oe_n_out,
    output logic [3:0]         hub_addr_out,
    output logic               row_done_out
);

    if (SYS_CLK_FREQ < 1 || SHIFT_CLK_DIV < 1 || BLANK_CYCLES < 1 ||
        OE_ON_CYCLES < 256 || (OE_ON_CYCLES % 256) != 0) begin : g_bad_params
        $error("hub75_row_driver: illegal parameter combination");
    end

    localparam int BLANK_W = $clog2(BLANK_CYCLES + 1);
    localparam int DISP_W  = $clog2(OE_ON_CYCLES + 1);

    localparam logic [BLANK_W-1:0]      BLANK_LAST  = BLANK_W'(BLANK_CYCLES - 1);
    localparam logic [DISP_W-1:0]       DISP_LAST   = DISP_W'(OE_ON_CYCLES - 1);
    localparam logic [DISP_W-1:0]       DISP_PENULT = DISP_W'(OE_ON_CYCLES - 2);
    localparam logic [GL_COL_IDX_W-1:0] COL_LAST    = GL_COL_IDX_W'(GL_NUM_COL_PIXELS - 1);

    hub75_state_t            state_q, state_d;
    rgb_row_t                row_q, row_d;
    logic [3:0]              addr_q, addr_d;
    logic [GL_COL_IDX_W-1:0] idx_q, idx_d;
    logic [BLANK_W-1:0]      blank_cnt_q, blank_cnt_d;
    logic [DISP_W-1:0]       disp_cnt_q, disp_cnt_d;

    logic                    ready_q, ready_d;
    logic [2:0]              top_bits_q, top_bits_d;
    logic [2:0]              bot_bits_q, bot_bits_d;
    logic                    hclk_q, hclk_d;
    logic                    lat_q, lat_d;
    logic                    oe_n_q, oe_n_d;
    logic [3:0]              hub_addr_q, hub_addr_d;
    logic                    done_q, done_d;

    logic                    tick_en;
    logic                    rise_tick;
    logic                    fall_tick;
    logic [GL_COL_IDX_W-1:0] idx_dec;

`ifdef HUB75_BRIGHTNESS_EN
    localparam int OE_STEP = OE_ON_CYCLES / 256;

    logic [DISP_W-1:0] on_len_q, on_len_d;
    logic [DISP_W-1:0] on_len_entry;

    // 255*OE_STEP < OE_ON_CYCLES, so the product always fits the display counter width.
    assign on_len_entry = DISP_W'(32'(brightness_in) * OE_STEP);
`endif

    // The divider only runs in the two states that need shift-clock timing; it restarts on each entry.
    assign tick_en = (state_q == SHIFT) || (state_q == LATCH);
    assign idx_dec = idx_q - 1'b1;

    hub75_tick_gen #(
        .DIV (SHIFT_CLK_DIV)
    ) u_tick_gen (
        .clk_in        (clk_in),
        .reset_in      (reset_in),
        .en_in         (tick_en),
        .rise_tick_out (rise_tick),
        .fall_tick_out (fall_tick)
    );

    always_comb begin
        state_d     = state_q;
        row_d       = row_q;
        addr_d      = addr_q;
        idx_d       = idx_q;
        blank_cnt_d = blank_cnt_q;
        disp_cnt_d  = disp_cnt_q;
        ready_d     = ready_q;
        top_bits_d  = top_bits_q;
        bot_bits_d  = bot_bits_q;
        hclk_d      = hclk_q;
        lat_d       = lat_q;
        oe_n_d      = oe_n_q;
        hub_addr_d  = hub_addr_q;
        done_d      = 1'b0;
`ifdef HUB75_BRIGHTNESS_EN
        on_len_d    = on_len_q;
`endif

        case (state_q)
            IDLE: begin
                ready_d = 1'b1;
                oe_n_d  = 1'b1;
                if (row_if.row_valid_in && ready_q) begin
                    // The first column goes out together with the capture so data is valid one cycle later.
                    row_d      = row_if.row_in;
                    addr_d     = row_if.row_address_in;
                    idx_d      = COL_LAST;
                    top_bits_d = half_bits(row_if.row_in.top, COL_LAST);
                    bot_bits_d = half_bits(row_if.row_in.bot, COL_LAST);
                    hclk_d     = 1'b0;
                    ready_d    = 1'b0;
                    state_d    = SHIFT;
                end
            end

            SHIFT: begin
                if (rise_tick) begin
                    hclk_d = 1'b1;
                end else if (fall_tick) begin
                    hclk_d = 1'b0;
                    if (idx_q == '0) begin
                        top_bits_d  = '0;
                        bot_bits_d  = '0;
                        blank_cnt_d = '0;
                        hub_addr_d  = addr_q;
                        state_d     = BLANK;
                    end else begin
                        idx_d      = idx_dec;
                        top_bits_d = half_bits(row_q.top, idx_dec);
                        bot_bits_d = half_bits(row_q.bot, idx_dec);
                    end
                end
            end

            BLANK: begin
                oe_n_d = 1'b1;
                if (blank_cnt_q == BLANK_LAST) begin
                    lat_d   = 1'b1;
                    state_d = LATCH;
                end else begin
                    blank_cnt_d = blank_cnt_q + 1'b1;
                end
            end

            LATCH: begin
                // Latch lasts one full shift-clock period: rise tick is ignored, fall tick ends it.
                if (fall_tick) begin
                    lat_d      = 1'b0;
                    disp_cnt_d = '0;
                    state_d    = DISPLAY;
`ifdef HUB75_BRIGHTNESS_EN
                    on_len_d   = on_len_entry;
                    oe_n_d     = (on_len_entry == '0);
`else
                    oe_n_d     = 1'b0;
`endif
                end
            end

            DISPLAY: begin
                if (disp_cnt_q == DISP_LAST) begin
                    oe_n_d  = 1'b1;
                    ready_d = 1'b1;
                    state_d = IDLE;
                end else begin
                    disp_cnt_d = disp_cnt_q + 1'b1;
                    done_d     = (disp_cnt_q == DISP_PENULT);
`ifdef HUB75_BRIGHTNESS_EN
                    // oe_n for the next cycle: low while the next cycle index is within the on-time.
                    oe_n_d     = !((disp_cnt_q + 1'b1) < on_len_q);
`else
                    oe_n_d     = 1'b0;
`endif
                end
            end

            default: begin
                oe_n_d  = 1'b1;
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_in or posedge reset_in) begin
        if (reset_in) begin
            state_q     <= IDLE;
            row_q       <= '0;
            addr_q      <= '0;
            idx_q       <= '0;
            blank_cnt_q <= '0;
            disp_cnt_q  <= '0;
            ready_q     <= 1'b0;
            top_bits_q  <= '0;
            bot_bits_q  <= '0;
            hclk_q      <= 1'b0;
            lat_q       <= 1'b0;
            oe_n_q      <= 1'b1;
            hub_addr_q  <= '0;
            done_q      <= 1'b0;
`ifdef HUB75_BRIGHTNESS_EN
            on_len_q    <= '0;
`endif
        end else begin
            state_q     <= state_d;
            row_q       <= row_d;
            addr_q      <= addr_d;
            idx_q       <= idx_d;
            blank_cnt_q <= blank_cnt_d;
            disp_cnt_q  <= disp_cnt_d;
            ready_q     <= ready_d;
            top_bits_q  <= top_bits_d;
            bot_bits_q  <= bot_bits_d;
            hclk_q      <= hclk_d;
            lat_q       <= lat_d;
            oe_n_q      <= oe_n_d;
            hub_addr_q  <= hub_addr_d;
            done_q      <= done_d;
`ifdef HUB75_BRIGHTNESS_EN
            on_len_q    <= on_len_d;
`endif
        end
    end

    assign row_if.row_ready_out = ready_q;
    assign hub_r1_out   = top_bits_q[2];
    assign hub_g1_out   = top_bits_q[1];
    assign hub_b1_out   = top_bits_q[0];
    assign hub_r2_out   = bot_bits_q[2];
    assign hub_g2_out   = bot_bits_q[1];
    assign hub_b2_out   = bot_bits_q[0];
    assign hub_clk_out  = hclk_q;
    assign hub_lat_out  = lat_q;
    assign hub_oe_n_out = oe_n_q;
    assign hub_addr_out = hub_addr_q;
    assign row_done_out = done_q;

endmodule

// File: tb/tb_hub75_row_driver.sv
// tb/tb_hub75_row_driver.sv - self-checking bench for hub75_row_driver
module tb_hub75_row_driver;
    import led_display_pkg::*;

    localparam int DIV       = 2;
    localparam int BLK       = 4;
    localparam int OE_ON     = 512;
    localparam int NCOL      = GL_NUM_COL_PIXELS;
    localparam int SHIFT_LEN = 2 * DIV * NCOL;
    localparam int LAT_START = SHIFT_LEN + BLK;
    localparam int DISP_STRT = LAT_START + 2 * DIV;
    localparam int ROW_LEN   = DISP_STRT + OE_ON;
    localparam int PERIOD    = ROW_LEN + 1;

    logic clk_in   = 1'b0;
    logic reset_in = 1'b1;
    always #5 clk_in = ~clk_in;

    hub75_row_driver_if row_if();

    logic       hub_r1_out, hub_g1_out, hub_b1_out;
    logic       hub_r2_out, hub_g2_out, hub_b2_out;
    logic       hub_clk_out, hub_lat_out, hub_oe_n_out, row_done_out;
    logic [3:0] hub_addr_out;
`ifdef HUB75_BRIGHTNESS_EN
    logic [7:0] brightness_in = 8'd255;
`endif

    hub75_row_driver #(
        .SYS_CLK_FREQ  (100_000_000),
        .SHIFT_CLK_DIV (DIV),
        .BLANK_CYCLES  (BLK),
        .OE_ON_CYCLES  (OE_ON)
    ) dut (
        .clk_in        (clk_in),
        .reset_in      (reset_in),
        .row_if        (row_if),
`ifdef HUB75_BRIGHTNESS_EN
        .brightness_in (brightness_in),
`endif
        .hub_r1_out    (hub_r1_out),
        .hub_g1_out    (hub_g1_out),
        .hub_b1_out    (hub_b1_out),
        .hub_r2_out    (hub_r2_out),
        .hub_g2_out    (hub_g2_out),
        .hub_b2_out    (hub_b2_out),
        .hub_clk_out   (hub_clk_out),
        .hub_lat_out   (hub_lat_out),
        .hub_oe_n_out  (hub_oe_n_out),
        .hub_addr_out  (hub_addr_out),
        .row_done_out  (row_done_out)
    );

    int n_vec = 0;
    int n_bad = 0;

    task automatic chk(input string name, input logic [191:0] act, input logic [191:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, want %0h", name, act, exp);
        end
    endtask

    typedef struct {
        rgb_row_t   data;
        int         rises, lat_cycles, first_lat, oe_low, first_oe, done_cnt, done_idx, viol;
        logic [3:0] addr_at_lat, addr_at_blank;
        logic       oe_at_lat;
    } obs_t;

    typedef struct {
        rgb_row_t    row;
        logic [3:0]  addr;
        logic [31:0] e_r1, e_g1, e_b1, e_r2, e_g2, e_b2;
    } vec_t;

    function automatic rgb_row_t mk_row(input logic [31:0] r1, g1, b1, r2, g2, b2);
        rgb_row_t r;
        r.top.red = r1; r.top.green = g1; r.top.blue = b1;
        r.bot.red = r2; r.bot.green = g2; r.bot.blue = b2;
        return r;
    endfunction

    function automatic rgb_row_t rand_row();
        return mk_row($urandom, $urandom, $urandom, $urandom, $urandom, $urandom);
    endfunction

    // Reference on-time: whole DISPLAY period, or brightness steps of OE_ON/256 cycles.
    function automatic int exp_on_cycles();
`ifdef HUB75_BRIGHTNESS_EN
        return int'(brightness_in) * (OE_ON / 256);
`else
        return OE_ON;
`endif
    endfunction

    task automatic wait_ready(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk_in);
            if (row_ready_out_tb()) begin
                ok = 1'b1;
                return;
            end
        end
        n_vec++;
        n_bad++;
        $display("FAIL ready_timeout: got ready=0 for 3000 cycles, want ready=1");
    endtask

    function automatic logic row_ready_out_tb();
        return row_if.row_ready_out;
    endfunction

    // Presents one row, then watches every cycle of its SHIFT..DISPLAY window while scribbling
    // over the inputs with valid held high (the driver must ignore that).
    task automatic run_row(input rgb_row_t r, input logic [3:0] a, output obs_t o);
        logic pc, pl, po;
        logic [3:0] pa;
        bit ok;
        o.data = '0; o.rises = 0; o.lat_cycles = 0; o.first_lat = -1; o.oe_low = 0;
        o.first_oe = -1; o.done_cnt = 0; o.done_idx = -1; o.viol = 0;
        o.addr_at_lat = 'x; o.addr_at_blank = 'x; o.oe_at_lat = 'x;
        wait_ready(ok);
        if (!ok) return;
        row_if.row_in = r;
        row_if.row_address_in = a;
        row_if.row_valid_in = 1'b1;
        pc = hub_clk_out; pl = hub_lat_out; po = hub_oe_n_out; pa = hub_addr_out;
        @(posedge clk_in);
        for (int c = 0; c < ROW_LEN; c++) begin
            @(negedge clk_in);
            if (c < 600) begin
                row_if.row_in = rand_row();
                row_if.row_address_in = 4'($urandom);
            end else begin
                row_if.row_valid_in = 1'b0;
            end
            if (hub_clk_out && !pc) begin
                o.rises++;
                o.data.top.red   = {o.data.top.red[NCOL-2:0],   hub_r1_out};
                o.data.top.green = {o.data.top.green[NCOL-2:0], hub_g1_out};
                o.data.top.blue  = {o.data.top.blue[NCOL-2:0],  hub_b1_out};
                o.data.bot.red   = {o.data.bot.red[NCOL-2:0],   hub_r2_out};
                o.data.bot.green = {o.data.bot.green[NCOL-2:0], hub_g2_out};
                o.data.bot.blue  = {o.data.bot.blue[NCOL-2:0],  hub_b2_out};
            end
            if (hub_lat_out) begin
                o.lat_cycles++;
                if (!pl) begin
                    o.first_lat   = c;
                    o.addr_at_lat = hub_addr_out;
                    o.oe_at_lat   = hub_oe_n_out;
                end
            end
            if (c == SHIFT_LEN) o.addr_at_blank = hub_addr_out;
            if (!hub_oe_n_out) begin
                if (o.oe_low == 0) o.first_oe = c;
                o.oe_low++;
            end
            if (row_done_out) begin
                o.done_cnt++;
                o.done_idx = c;
            end
            if (!po && (hub_addr_out !== pa || hub_lat_out !== pl)) o.viol++;
            pc = hub_clk_out; pl = hub_lat_out; po = hub_oe_n_out; pa = hub_addr_out;
        end
    endtask

    task automatic check_row(input string tag, input obs_t o, input rgb_row_t exp_stream, input logic [3:0] a);
        int on;
        on = exp_on_cycles();
        chk({tag, ".data"},       o.data, exp_stream);
        chk({tag, ".rises"},      o.rises, NCOL);
        chk({tag, ".addr_blank"}, o.addr_at_blank, a);
        chk({tag, ".addr_lat"},   o.addr_at_lat, a);
        chk({tag, ".oe_at_lat"},  o.oe_at_lat, 1'b1);
        chk({tag, ".lat_start"},  o.first_lat, LAT_START);
        chk({tag, ".lat_len"},    o.lat_cycles, 2 * DIV);
        chk({tag, ".oe_low"},     o.oe_low, on);
        if (on > 0) chk({tag, ".oe_start"}, o.first_oe, DISP_STRT);
        chk({tag, ".done_cnt"},   o.done_cnt, 1);
        chk({tag, ".done_idx"},   o.done_idx, ROW_LEN - 1);
        chk({tag, ".viol"},       o.viol, 0);
    endtask

    task automatic mid_reset(input string tag, input bit in_display);
        bit ok;
        logic [21:0] outs;
        wait_ready(ok);
        if (!ok) return;
        row_if.row_in = mk_row(32'hFFFF_FFFF, 0, 0, 0, 0, 32'hFFFF_FFFF);
        row_if.row_address_in = 4'h9;
        row_if.row_valid_in = 1'b1;
        @(posedge clk_in);
        ok = 1'b0;
        for (int i = 0; i < 2000 && !ok; i++) begin
            @(negedge clk_in);
            row_if.row_valid_in = 1'b0;
            ok = in_display ? !hub_oe_n_out : (hub_clk_out && hub_r1_out);
        end
        chk({tag, ".reached"}, ok, 1'b1);
        #2 reset_in = 1'b1;
        #1;
        outs = {row_if.row_ready_out, hub_r1_out, hub_g1_out, hub_b1_out, hub_r2_out, hub_g2_out,
                hub_b2_out, hub_clk_out, hub_lat_out, hub_oe_n_out, hub_addr_out, row_done_out, 8'h00};
        chk({tag, ".async_outs"}, outs, {1'b0, 6'b0, 1'b0, 1'b0, 1'b1, 4'h0, 1'b0, 8'h00});
        @(negedge clk_in);
        reset_in = 1'b0;
        #1 chk({tag, ".ready_at_release"}, row_if.row_ready_out, 1'b0);
        @(negedge clk_in);
        chk({tag, ".ready_after_edge"}, row_if.row_ready_out, 1'b1);
    endtask

    initial begin
        #900_000;
        $display("FAIL watchdog: got simulation still running, want finished");
        $fatal(1, "watchdog expired");
    end

    vec_t tbl[4];
    obs_t o;

    initial begin
        bit ok;
        int caps[$];
        rgb_row_t r;

        tbl[0] = '{mk_row(0, 0, 0, 0, 0, 0), 4'h0, 0, 0, 0, 0, 0, 0};
        tbl[1] = '{mk_row(32'h8000_0001, 0, 0, 0, 0, 0), 4'h5, 32'h8000_0001, 0, 0, 0, 0, 0};
        tbl[2] = '{mk_row(32'hDEAD_BEEF, 32'h1234_5678, 32'h0F0F_0F0F, 32'hFFFF_FFFF, 32'h8000_0000, 32'h0000_0001),
                   4'hF, 32'hDEAD_BEEF, 32'h1234_5678, 32'h0F0F_0F0F, 32'hFFFF_FFFF, 32'h8000_0000, 32'h0000_0001};
        tbl[3] = '{mk_row(0, 32'hAAAA_AAAA, 0, 32'h5555_5555, 0, 0), 4'hA, 0, 32'hAAAA_AAAA, 0, 32'h5555_5555, 0, 0};

        row_if.row_in = '0;
        row_if.row_address_in = '0;
        row_if.row_valid_in = 1'b0;

        // Reset state, then ready one edge after release.
        #12;
        chk("reset.outs", {row_if.row_ready_out, hub_r1_out, hub_g1_out, hub_b1_out, hub_r2_out, hub_g2_out,
                           hub_b2_out, hub_clk_out, hub_lat_out, hub_oe_n_out, hub_addr_out, row_done_out},
            {1'b0, 6'b0, 1'b0, 1'b0, 1'b1, 4'h0, 1'b0});
        @(negedge clk_in);
        reset_in = 1'b0;
        @(negedge clk_in);
        chk("reset.ready_after_edge", row_if.row_ready_out, 1'b1);

        // Table vectors with explicit expected serial streams.
        for (int i = 0; i < 4; i++) begin
            run_row(tbl[i].row, tbl[i].addr, o);
            check_row($sformatf("tbl%0d", i), o,
                      mk_row(tbl[i].e_r1, tbl[i].e_g1, tbl[i].e_b1, tbl[i].e_r2, tbl[i].e_g2, tbl[i].e_b2),
                      tbl[i].addr);
        end

        // Random rows over all 16 addresses; model: stream is the captured row, MSB column first.
        for (int a = 0; a < 16; a++) begin
            r = rand_row();
            run_row(r, 4'(a), o);
            check_row($sformatf("rnd_addr%0d", a), o, r, 4'(a));
        end

        // Back-to-back rows with valid held high.
        wait_ready(ok);
        row_if.row_in = rand_row();
        row_if.row_address_in = 4'h3;
        row_if.row_valid_in = 1'b1;
        for (int c = 0; c < 3 * PERIOD; c++) begin
            if (c > 0) @(negedge clk_in);
            if (row_if.row_ready_out) caps.push_back(c);
            if (c == 2 * PERIOD + 1) row_if.row_valid_in = 1'b0;
        end
        chk("b2b.accepts", caps.size(), 3);
        if (caps.size() >= 3) begin
            chk("b2b.gap1", caps[1] - caps[0], PERIOD);
            chk("b2b.gap2", caps[2] - caps[1], PERIOD);
        end

        // Reset mid-operation.
        mid_reset("rst_shift", 1'b0);
        mid_reset("rst_display", 1'b1);

`ifdef HUB75_BRIGHTNESS_EN
        begin
            logic [7:0] levels [3];
            levels[0] = 8'd0; levels[1] = 8'd128; levels[2] = 8'd255;
            for (int i = 0; i < 3; i++) begin
                brightness_in = levels[i];
                r = rand_row();
                run_row(r, 4'h7, o);
                check_row($sformatf("bright%0d", levels[i]), o, r, 4'h7);
            end
        end
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
